// File: rtl/cfi_backend_shadow_stack_pkg.sv
// Types and constants shared by the CFI checking backend and its shadow stack.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package cfi_backend_shadow_stack_pkg;

    // Native address width of the core; the backend's XLEN parameter defaults to this.
    localparam int unsigned CFI_XLEN = 64;

    typedef enum logic [1:0] {
        CF_BRANCH = 2'd0,
        CF_JUMP   = 2'd1,
        CF_CALL   = 2'd2,
        CF_RETURN = 2'd3
    } cf_type_t;

    // One retired control-flow event as logged by the CFI stage.
    typedef struct packed {
        logic [CFI_XLEN-1:0] pc;
        logic [CFI_XLEN-1:0] target;
        cf_type_t            cf_type;
        logic                is_compressed;
    } cfi_log_t;

    // Fault report handed to commit.
    typedef struct packed {
        logic                valid;
        logic [CFI_XLEN-1:0] cause;
        logic [CFI_XLEN-1:0] tval;
    } exception_t;

    localparam logic [CFI_XLEN-1:0] CFI_CAUSE_SS_MISMATCH  = CFI_XLEN'(18);
    localparam logic [CFI_XLEN-1:0] CFI_CAUSE_SS_OVERFLOW  = CFI_XLEN'(24);
    localparam logic [CFI_XLEN-1:0] CFI_CAUSE_SS_UNDERFLOW = CFI_XLEN'(25);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FAULT = 1'b1
    } bss_state_t;

endpackage

// File: rtl/cfi_shadow_stack.sv
// Register-array LIFO holding predicted return addresses.
// Latency: push/pop/clear take effect at the clock edge; top_o reflects the previous edge.
// Backpressure: none; the caller must not push when full or pop when empty (ignored if it does).
module cfi_shadow_stack #(
    parameter int unsigned SS_DEPTH = 32,
    parameter int unsigned XLEN     = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        clear_i,
    input  logic [XLEN-1:0]             data_i,
    output logic [XLEN-1:0]             top_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(SS_DEPTH):0]   depth_o
);

    localparam int unsigned AW = $clog2(SS_DEPTH);
    localparam int unsigned DW = AW + 1;

    // Entries need no reset: only slots below the pointer are ever read.
    logic [XLEN-1:0] mem_q [SS_DEPTH];
    logic [DW-1:0]   ptr_q;
    logic [DW-1:0]   ptr_d;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   top_idx;

    assign wr_idx  = ptr_q[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign full_o  = (ptr_q == DW'(SS_DEPTH));
    assign empty_o = (ptr_q == '0);
    assign top_o   = mem_q[top_idx];
    assign depth_o = ptr_q;

    // Next pointer: clear beats push, push and pop are never requested together.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (push_i && !full_o) begin
            ptr_d = ptr_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - DW'(1);
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Entry write on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o && !clear_i) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/cfi_backend_shadow_stack.sv
// CFI checking backend: shadow stack of return addresses, pushes on calls, checks returns.
// Latency: one log entry consumed per cycle in IDLE; fault visible one cycle after the offending entry.
// Backpressure: stops popping while a fault is held, so the queue fills and upstream stalls.
module cfi_backend_shadow_stack
    import cfi_backend_shadow_stack_pkg::*;
#(
    parameter int unsigned SS_DEPTH = 32,
    parameter int unsigned XLEN     = CFI_XLEN
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  cfi_log_t                    log_i,
    input  logic                        queue_empty_i,
    output logic                        queue_pop_o,
    input  logic                        flush_i,
    input  logic                        fault_ack_i,
    output exception_t                  cfi_fault_o,
    output logic [$clog2(SS_DEPTH):0]   ss_depth_o
);

    bss_state_t      state_q;
    bss_state_t      state_d;
    exception_t      fault_q;
    exception_t      fault_d;

    logic            ss_push;
    logic            ss_pop;
    logic            ss_clear;
    logic            ss_full;
    logic            ss_empty;
    logic [XLEN-1:0] ss_top;
    logic [XLEN-1:0] ret_addr;

    // Return address of a call, wrapping naturally at XLEN bits.
    assign ret_addr = log_i.pc + (log_i.is_compressed ? XLEN'(2) : XLEN'(4));

    cfi_shadow_stack #(
        .SS_DEPTH (SS_DEPTH),
        .XLEN     (XLEN)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ss_push),
        .pop_i   (ss_pop),
        .clear_i (ss_clear),
        .data_i  (ret_addr),
        .top_o   (ss_top),
        .full_o  (ss_full),
        .empty_o (ss_empty),
        .depth_o (ss_depth_o)
    );

    // Classify the head entry, drive stack controls, and decide the next state / fault.
    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        queue_pop_o = 1'b0;
        ss_push     = 1'b0;
        ss_pop      = 1'b0;
        ss_clear    = flush_i;

        case (state_q)
            ST_IDLE: begin
                if (!queue_empty_i && !rst_i) begin
                    // Every entry is consumed, including the one that faults.
                    queue_pop_o = 1'b1;
                    case (log_i.cf_type)
                        CF_CALL: begin
                            if (ss_full) begin
                                state_d       = ST_FAULT;
                                fault_d.valid = 1'b1;
                                fault_d.cause = CFI_CAUSE_SS_OVERFLOW;
                                fault_d.tval  = log_i.pc;
                            end else begin
                                // A coincident flush drops the push.
                                ss_push = !flush_i;
                            end
                        end
                        CF_RETURN: begin
                            if (ss_empty) begin
                                state_d       = ST_FAULT;
                                fault_d.valid = 1'b1;
                                fault_d.cause = CFI_CAUSE_SS_UNDERFLOW;
                                fault_d.tval  = log_i.target;
                            end else if (log_i.target == ss_top) begin
                                ss_pop = 1'b1;
                            end else begin
                                state_d       = ST_FAULT;
                                fault_d.valid = 1'b1;
                                fault_d.cause = CFI_CAUSE_SS_MISMATCH;
                                fault_d.tval  = log_i.target;
                            end
                        end
                        default: begin
                            // Branches and jumps are not checked here.
                        end
                    endcase
                end
            end
            ST_FAULT: begin
                if (fault_ack_i) begin
                    state_d  = ST_IDLE;
                    fault_d  = '0;
                    ss_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and held fault report.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign cfi_fault_o = fault_q;

endmodule

// File: tb/tb_cfi_backend_shadow_stack.sv
// Directed scoreboard bench for the CFI shadow-stack backend.
// Stimulus pushes expected pop/fault events; a negedge monitor pops and compares them.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_cfi_backend_shadow_stack;
    import cfi_backend_shadow_stack_pkg::*;

    localparam int unsigned DEPTH = 32;

    logic                     clk;
    logic                     rst;
    cfi_log_t                 log_i;
    logic                     queue_empty_i;
    logic                     queue_pop_o;
    logic                     flush_i;
    logic                     fault_ack_i;
    exception_t               cfi_fault_o;
    logic [$clog2(DEPTH):0]   ss_depth_o;

    typedef struct {
        bit          is_fault;
        logic [63:0] cause;
        logic [63:0] tval;
        int          depth;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    cfi_backend_shadow_stack #(.SS_DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .log_i         (log_i),
        .queue_empty_i (queue_empty_i),
        .queue_pop_o   (queue_pop_o),
        .flush_i       (flush_i),
        .fault_ack_i   (fault_ack_i),
        .cfi_fault_o   (cfi_fault_o),
        .ss_depth_o    (ss_depth_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present an entry at the queue head without expecting it to be consumed yet.
    task automatic present(input logic [63:0] pc, input logic [63:0] tgt, input cf_type_t t,
                           input bit c, input bit fl);
        log_i.pc            = pc;
        log_i.target        = tgt;
        log_i.cf_type       = t;
        log_i.is_compressed = c;
        queue_empty_i       = 1'b0;
        flush_i             = fl;
    endtask

    // Issue one entry that must be popped this cycle while the stack holds d entries.
    task automatic send(input logic [63:0] pc, input logic [63:0] tgt, input cf_type_t t,
                        input bit c, input bit fl, input int d);
        exp_q.push_back('{is_fault: 1'b0, cause: 64'd0, tval: 64'd0, depth: d});
        present(pc, tgt, t, c, fl);
        @(posedge clk); #1;
        queue_empty_i = 1'b1;
        flush_i       = 1'b0;
    endtask

    task automatic expect_fault(input logic [63:0] cause, input logic [63:0] tval, input int d);
        exp_q.push_back('{is_fault: 1'b1, cause: cause, tval: tval, depth: d});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Acknowledge the held fault while an entry waits at the head; it must pop the cycle after.
    task automatic ack_with_pending();
        fault_ack_i = 1'b1;
        exp_q.push_back('{is_fault: 1'b0, cause: 64'd0, tval: 64'd0, depth: 0});
        @(posedge clk); #1;
        fault_ack_i = 1'b0;
        chk("ack_valid_cleared", 64'(cfi_fault_o.valid), 64'd0);
        chk("ack_depth_cleared", 64'(ss_depth_o), 64'd0);
        @(posedge clk); #1;
        queue_empty_i = 1'b1;
    endtask

    // Monitor: every pop and every fault onset must match the next scoreboard entry.
    initial begin
        exp_t       e;
        logic       prev_v;
        exception_t prev_f;
        prev_v = 1'b0;
        prev_f = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (queue_pop_o) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_pop: got pop=1 expected pop=0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind_pop", 64'd0, 64'(e.is_fault));
                        chk("pop_depth", 64'(ss_depth_o), 64'(e.depth));
                    end
                end
                if (cfi_fault_o.valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_fault: got cause 0x%0h expected no fault at %0t",
                                 cfi_fault_o.cause, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind_fault", 64'd1, 64'(e.is_fault));
                        chk("fault_cause", cfi_fault_o.cause, e.cause);
                        chk("fault_tval", cfi_fault_o.tval, e.tval);
                        chk("fault_depth", 64'(ss_depth_o), 64'(e.depth));
                    end
                end else if (cfi_fault_o.valid && prev_v) begin
                    chk("fault_hold_cause", cfi_fault_o.cause, prev_f.cause);
                    chk("fault_hold_tval", cfi_fault_o.tval, prev_f.tval);
                    chk("fault_hold_nopop", 64'(queue_pop_o), 64'd0);
                end
            end
            prev_v = cfi_fault_o.valid;
            prev_f = cfi_fault_o;
        end
    end

    initial begin
        rst           = 1'b1;
        log_i         = '0;
        queue_empty_i = 1'b0;
        flush_i       = 1'b0;
        fault_ack_i   = 1'b0;

        // Reset state, with an entry presented to show pop is held low.
        #2;
        chk("rst_valid", 64'(cfi_fault_o.valid), 64'd0);
        chk("rst_cause", cfi_fault_o.cause, 64'd0);
        chk("rst_tval", cfi_fault_o.tval, 64'd0);
        chk("rst_depth", 64'(ss_depth_o), 64'd0);
        chk("rst_pop", 64'(queue_pop_o), 64'd0);
        queue_empty_i = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Matching call/return, back to back.
        send(64'h8000_0100, 64'h0, CF_CALL, 1'b0, 1'b0, 0);
        send(64'h0, 64'h8000_0104, CF_RETURN, 1'b0, 1'b0, 1);
        chk("t1_depth", 64'(ss_depth_o), 64'd0);
        chk("t1_valid", 64'(cfi_fault_o.valid), 64'd0);

        // Compressed call returns to pc+2, so pc+4 is a mismatch.
        send(64'h8000_0200, 64'h0, CF_CALL, 1'b1, 1'b0, 0);
        send(64'h0, 64'h8000_0204, CF_RETURN, 1'b0, 1'b0, 1);
        expect_fault(64'd18, 64'h8000_0204, 1);
        chk("t2_valid_latency", 64'(cfi_fault_o.valid), 64'd1);
        chk("t2_depth_kept", 64'(ss_depth_o), 64'd1);
        present(64'h8000_0208, 64'h8000_0300, CF_BRANCH, 1'b0, 1'b0);
        cycles(3);
        chk("t2_pop_held", 64'(queue_pop_o), 64'd0);
        ack_with_pending();

        // Underflow, fault held for 10 cycles with an entry waiting.
        send(64'h0, 64'h8000_0300, CF_RETURN, 1'b0, 1'b0, 0);
        expect_fault(64'd25, 64'h8000_0300, 0);
        present(64'h8000_0310, 64'h8000_0400, CF_JUMP, 1'b0, 1'b0);
        cycles(10);
        chk("t3_valid_held", 64'(cfi_fault_o.valid), 64'd1);
        chk("t3_tval_held", cfi_fault_o.tval, 64'h8000_0300);
        ack_with_pending();

        // Fill the stack, then one more call overflows.
        for (int k = 0; k <= int'(DEPTH); k++) begin
            send(64'h8000_1000 + 64'(4 * k), 64'h0, CF_CALL, 1'b0, 1'b0, k);
        end
        expect_fault(64'd24, 64'h8000_1080, int'(DEPTH));
        chk("t4_depth_full", 64'(ss_depth_o), 64'(DEPTH));
        present(64'h8000_2000, 64'h8000_2100, CF_BRANCH, 1'b0, 1'b0);
        cycles(2);
        ack_with_pending();

        // Flush beats a coincident call; following return underflows.
        send(64'h8000_2000, 64'h0, CF_CALL, 1'b0, 1'b0, 0);
        send(64'h8000_2004, 64'h0, CF_CALL, 1'b0, 1'b0, 1);
        send(64'h8000_2008, 64'h0, CF_CALL, 1'b0, 1'b0, 2);
        send(64'h8000_200C, 64'h0, CF_CALL, 1'b0, 1'b1, 3);
        chk("t5_depth_flushed", 64'(ss_depth_o), 64'd0);
        send(64'h0, 64'h8000_2010, CF_RETURN, 1'b0, 1'b0, 0);
        expect_fault(64'd25, 64'h8000_2010, 0);
        present(64'h8000_2020, 64'h8000_2100, CF_BRANCH, 1'b0, 1'b0);
        ack_with_pending();

        // Return address wraps to zero at the top of the address space.
        send(64'hFFFF_FFFF_FFFF_FFFE, 64'h0, CF_CALL, 1'b1, 1'b0, 0);
        send(64'h0, 64'h0, CF_RETURN, 1'b0, 1'b0, 1);
        // Nested calls and returns with no bubbles.
        send(64'h8000_4000, 64'h0, CF_CALL, 1'b0, 1'b0, 0);
        send(64'h8000_4010, 64'h0, CF_CALL, 1'b1, 1'b0, 1);
        send(64'h0, 64'h8000_4012, CF_RETURN, 1'b0, 1'b0, 2);
        send(64'h8000_4020, 64'h0, CF_CALL, 1'b0, 1'b0, 1);
        send(64'h0, 64'h8000_4024, CF_RETURN, 1'b0, 1'b0, 2);
        send(64'h0, 64'h8000_4004, CF_RETURN, 1'b0, 1'b0, 1);
        chk("t6_depth", 64'(ss_depth_o), 64'd0);
        chk("t6_valid", 64'(cfi_fault_o.valid), 64'd0);
        // Difference only in the upper half must still mismatch.
        send(64'h8000_5000, 64'h0, CF_CALL, 1'b0, 1'b0, 0);
        send(64'h0, 64'h1_8000_5004, CF_RETURN, 1'b0, 1'b0, 1);
        expect_fault(64'd18, 64'h1_8000_5004, 1);
        present(64'h8000_5010, 64'h8000_5100, CF_JUMP, 1'b0, 1'b0);
        ack_with_pending();

        // Async reset while a fault is held.
        send(64'h0, 64'h8000_6000, CF_RETURN, 1'b0, 1'b0, 0);
        expect_fault(64'd25, 64'h8000_6000, 0);
        present(64'h8000_6010, 64'h8000_6100, CF_BRANCH, 1'b0, 1'b0);
        cycles(2);
        #2 rst = 1'b1;
        #1;
        chk("rst_fault_valid", 64'(cfi_fault_o.valid), 64'd0);
        chk("rst_fault_cause", cfi_fault_o.cause, 64'd0);
        chk("rst_fault_tval", cfi_fault_o.tval, 64'd0);
        chk("rst_fault_pop", 64'(queue_pop_o), 64'd0);
        queue_empty_i = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Async reset mid-stream with a non-empty stack.
        send(64'h8000_7000, 64'h0, CF_CALL, 1'b0, 1'b0, 0);
        send(64'h8000_7004, 64'h0, CF_CALL, 1'b0, 1'b0, 1);
        present(64'h8000_7008, 64'h0, CF_CALL, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_stream_depth", 64'(ss_depth_o), 64'd0);
        chk("rst_stream_pop", 64'(queue_pop_o), 64'd0);
        queue_empty_i = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send(64'h8000_8000, 64'h8000_8100, CF_BRANCH, 1'b0, 1'b0, 0);
        send(64'h8000_8004, 64'h8000_8200, CF_JUMP, 1'b0, 1'b0, 0);
        send(64'h8000_8008, 64'h8000_8300, CF_BRANCH, 1'b0, 1'b0, 0);
        send(64'h8000_800C, 64'h8000_8400, CF_JUMP, 1'b0, 1'b0, 0);
        cycles(3);
        chk("post_rst_valid", 64'(cfi_fault_o.valid), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
